simd_lane_alu: RTL

- Multi-cycle packed-SIMD arithmetic unit. Generalises the processor's byte-vector add/avg ops to a parametrised lane width.
- Adds saturating add/sub, min/max and an iterative per-lane multiply.
- Sits beside the scalar ALU as a custom-opcode execution unit. Operands and results pass through a valid/ready handshake so the core can stall on multi-cycle ops.

---
 rtl/simd_lane_alu_pkg.sv | 24 ++
 rtl/simd_lane_alu_if.sv | 25 ++
 rtl/simd_lane.sv | 63 ++++++
 rtl/simd_lane_alu.sv | 128 ++++++++++++
 4 files changed

// File: rtl/simd_lane_alu_pkg.sv
// Shared definitions for the packed-SIMD lane ALU: op encoding, FSM states
// and the lane-width legality check.
package simd_pkg;

   localparam logic [2:0] OP_ADD_V  = 3'b000;
   localparam logic [2:0] OP_AVG_V  = 3'b001;
   localparam logic [2:0] OP_ADDS_V = 3'b010;
   localparam logic [2:0] OP_SUB_V  = 3'b011;
   localparam logic [2:0] OP_SUBS_V = 3'b100;
   localparam logic [2:0] OP_MUL_V  = 3'b101;
   localparam logic [2:0] OP_MAX_V  = 3'b110;
   localparam logic [2:0] OP_MIN_V  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic bit lane_w_legal(input int lw, input int xlen);
      return ((lw == 8) || (lw == 16) || (lw == 32)) && ((xlen % lw) == 0);
   endfunction

endpackage

// File: rtl/simd_lane_alu_if.sv
// Operation/result handshake bundle between the core and the SIMD lane ALU.
interface simd_lane_alu_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            res_zero;
   logic            busy;

   modport master (
      output in_valid, op, src_a, src_b, out_ready,
      input  in_ready, out_valid, result, res_zero, busy
   );

   modport slave (
      input  in_valid, op, src_a, src_b, out_ready,
      output in_ready, out_valid, result, res_zero, busy
   );
endinterface

// File: rtl/simd_lane.sv
// One SIMD lane: combinational single-cycle ops plus the shift-add multiply
// datapath (accumulator, shifted multiplicand, shifted multiplier).
module simd_lane
   import simd_pkg::*;
#(
   parameter int LANE_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        op,
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   input  logic              load,
   input  logic              step,
   output logic [LANE_W-1:0] alu_res,
   output logic [LANE_W-1:0] acc
);

   logic [LANE_W:0]   sum_s;
   logic [LANE_W-1:0] diff_s;
   logic [LANE_W-1:0] acc_r;
   logic [LANE_W-1:0] mcand_r;
   logic [LANE_W-1:0] mplier_r;

   assign sum_s  = {1'b0, a} + {1'b0, b};
   assign diff_s = a - b;
   assign acc    = acc_r;

   // Single-cycle lane operations; the wide sum keeps the carry for avg/adds.
   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD_V:  alu_res = sum_s[LANE_W-1:0];
         OP_AVG_V:  alu_res = sum_s[LANE_W:1];
         OP_ADDS_V: alu_res = sum_s[LANE_W] ? {LANE_W{1'b1}} : sum_s[LANE_W-1:0];
         OP_SUB_V:  alu_res = diff_s;
         OP_SUBS_V: alu_res = (a >= b) ? diff_s : '0;
         OP_MAX_V:  alu_res = (a >= b) ? a : b;
         OP_MIN_V:  alu_res = (a <= b) ? a : b;
         default:   alu_res = '0;
      endcase
   end

   // Multiply step registers: only the low LANE_W product bits are kept.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r    <= '0;
         mcand_r  <= '0;
         mplier_r <= '0;
      end else if (load) begin
         acc_r    <= '0;
         mcand_r  <= a;
         mplier_r <= b;
      end else if (step) begin
         if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
         end
         mcand_r  <= mcand_r << 1;
         mplier_r <= mplier_r >> 1;
      end
   end

endmodule

// File: rtl/simd_lane_alu.sv
// Packed-SIMD execution unit: per-lane add/avg/saturating/min/max in one
// cycle, iterative per-lane multiply, valid/ready on both sides.
module simd_lane_alu
   import simd_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int LANE_W = 8
) (
   input logic           clk,
   input logic           reset,
   simd_lane_alu_if.slave bus
);

   localparam int LANES = XLEN / LANE_W;
   localparam int CNT_W = $clog2(LANE_W + 1);

   if (!lane_w_legal(LANE_W, XLEN)) begin : g_bad_lane_w
      $error("simd_lane_alu: LANE_W must be 8, 16 or 32 and divide XLEN");
   end

   state_t            state_r;
   state_t            state_next_s;
   logic [CNT_W-1:0]  cnt_r;
   logic              busy_r;
   logic              in_ready_r;
   logic              out_valid_r;
   logic [XLEN-1:0]   result_r;
   logic              res_zero_r;
   logic              mul_load_s;
   logic              mul_step_s;
   logic              result_load_s;
   logic [XLEN-1:0]   result_next_s;
   logic [XLEN-1:0]   alu_res_s;
   logic [XLEN-1:0]   acc_s;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      simd_lane #(.LANE_W(LANE_W)) u_lane (
         .clk     (clk),
         .reset   (reset),
         .op      (bus.op),
         .a       (bus.src_a[l*LANE_W +: LANE_W]),
         .b       (bus.src_b[l*LANE_W +: LANE_W]),
         .load    (mul_load_s),
         .step    (mul_step_s),
         .alu_res (alu_res_s[l*LANE_W +: LANE_W]),
         .acc     (acc_s[l*LANE_W +: LANE_W])
      );
   end

   // Next-state and datapath strobes.
   always_comb begin
      state_next_s  = state_r;
      mul_load_s    = 1'b0;
      mul_step_s    = 1'b0;
      result_load_s = 1'b0;
      result_next_s = alu_res_s;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid && in_ready_r) begin
               if (bus.op == OP_MUL_V) begin
                  state_next_s = ST_MUL;
                  mul_load_s   = 1'b1;
               end else begin
                  state_next_s  = ST_DONE;
                  result_load_s = 1'b1;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_MUL: begin
            // One extra cycle after the last step lets the accumulators settle into result.
            if (cnt_r == CNT_W'(LANE_W)) begin
               state_next_s  = ST_DONE;
               result_load_s = 1'b1;
               result_next_s = acc_s;
            end else begin
               mul_step_s = 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_DONE;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State, step counter and registered handshake/result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         busy_r      <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         result_r    <= '0;
         res_zero_r  <= 1'b1;
      end else begin
         state_r     <= state_next_s;
         in_ready_r  <= (state_next_s == ST_IDLE);
         out_valid_r <= (state_next_s == ST_DONE);
         if (mul_load_s) begin
            cnt_r  <= '0;
            busy_r <= 1'b1;
         end else if (mul_step_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_W'(LANE_W - 1)) begin
               busy_r <= 1'b0;
            end
         end
         if (result_load_s) begin
            result_r   <= result_next_s;
            res_zero_r <= (result_next_s == '0);
         end
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.res_zero  = res_zero_r;
   assign bus.busy      = busy_r;

endmodule
